// File: rtl/iterative_alu.sv
// Purpose : EX-stage ALU; logic/add/sub/compare/branch ops in one cycle, shifts one bit per cycle.
// Latency : 1 cycle for non-shift ops and zero-amount shifts, 1+shamt cycles for shifts.
// Backpr. : valid/ready both sides; result held in DONE until out_ready, in_ready low while shifting.
//
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   flush           abort held/in-flight op (branch mispredict), beats everything except rst_n
//   in_valid/in_ready, operation, src_a, src_b   op request (src_b[SHW-1:0] = shamt for shifts)
//   out_valid/out_ready, result, branch_taken, zero   registered response
//   busy            block is not idle
module iterative_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       operation,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             branch_taken,
   output logic             zero,
   output logic             busy
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_BEQ  = 4'b1000;
   localparam logic [3:0] OP_BNE  = 4'b1001;
   localparam logic [3:0] OP_SLT  = 4'b1010;
   localparam logic [3:0] OP_SLTU = 4'b1011;
   localparam logic [3:0] OP_BLT  = 4'b1100;
   localparam logic [3:0] OP_BGE  = 4'b1101;
   localparam logic [3:0] OP_BLTU = 4'b1110;
   localparam logic [3:0] OP_BGEU = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   // Low two opcode bits of the captured shift: 00 SLL, 01 SRL, 11 SRA.
   logic [1:0]       shift_kind_q, shift_kind_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             branch_taken_q, branch_taken_d;
   logic             zero_q, zero_d;

   logic             accept;
   logic             is_shift;
   logic [SHW-1:0]   shamt;
   logic             lt_s, lt_u, eq;
   logic [WIDTH-1:0] calc_res;
   logic             calc_br;
   logic [WIDTH-1:0] acc_shifted;

   assign in_ready = !flush && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
   assign accept   = in_valid && in_ready;

   assign shamt    = src_b[SHW-1:0];
   assign is_shift = (operation == OP_SLL) || (operation == OP_SRL) || (operation == OP_SRA);
   assign lt_s     = $signed(src_a) < $signed(src_b);
   assign lt_u     = src_a < src_b;
   assign eq       = src_a == src_b;

   // Single-cycle result. Shifts only reach here with shamt==0, so they pass src_a through;
   // non-zero shifts go through the one-bit iterative path instead of a barrel shifter.
   always_comb begin
      calc_res = '0;
      calc_br  = 1'b0;
      case (operation)
         OP_AND:  calc_res = src_a & src_b;
         OP_OR:   calc_res = src_a | src_b;
         OP_ADD:  calc_res = src_a + src_b;
         OP_XOR:  calc_res = src_a ^ src_b;
         OP_SUB:  calc_res = src_a - src_b;
         OP_SLL,
         OP_SRL,
         OP_SRA:  calc_res = src_a;
         OP_SLT:  calc_res = {{(WIDTH-1){1'b0}}, lt_s};
         OP_SLTU: calc_res = {{(WIDTH-1){1'b0}}, lt_u};
         OP_BEQ:  calc_br  = eq;
         OP_BNE:  calc_br  = !eq;
         OP_BLT:  calc_br  = lt_s;
         OP_BGE:  calc_br  = !lt_s;
         OP_BLTU: calc_br  = lt_u;
         OP_BGEU: calc_br  = !lt_u;
         default: calc_res = '0;
      endcase
   end

   always_comb begin
      acc_shifted = acc_q;
      case (shift_kind_q)
         2'b00:   acc_shifted = {acc_q[WIDTH-2:0], 1'b0};
         2'b01:   acc_shifted = {1'b0, acc_q[WIDTH-1:1]};
         2'b11:   acc_shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
         default: acc_shifted = acc_q;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      acc_d          = acc_q;
      cnt_d          = cnt_q;
      shift_kind_d   = shift_kind_q;
      out_valid_d    = out_valid_q;
      result_d       = result_q;
      branch_taken_d = branch_taken_q;
      zero_d         = zero_q;

      if (flush) begin
         state_d     = ST_IDLE;
         out_valid_d = 1'b0;
         cnt_d       = '0;
      end else begin
         case (state_q)
            ST_IDLE,
            ST_DONE: begin
               if (accept) begin
                  if (is_shift && (shamt != '0)) begin
                     state_d      = ST_SHIFT;
                     acc_d        = src_a;
                     cnt_d        = shamt;
                     shift_kind_d = operation[1:0];
                     out_valid_d  = 1'b0;
                  end else begin
                     state_d        = ST_DONE;
                     out_valid_d    = 1'b1;
                     result_d       = calc_res;
                     branch_taken_d = calc_br;
                     zero_d         = (calc_res == '0);
                  end
               end else if ((state_q == ST_DONE) && out_ready) begin
                  state_d     = ST_IDLE;
                  out_valid_d = 1'b0;
               end
            end
            ST_SHIFT: begin
               acc_d = acc_shifted;
               cnt_d = cnt_q - CNT_ONE;
               // Last shift step: publish the final accumulator directly.
               if (cnt_q == CNT_ONE) begin
                  state_d        = ST_DONE;
                  out_valid_d    = 1'b1;
                  result_d       = acc_shifted;
                  branch_taken_d = 1'b0;
                  zero_d         = (acc_shifted == '0);
               end
            end
            default: begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         acc_q          <= '0;
         cnt_q          <= '0;
         shift_kind_q   <= 2'b00;
         out_valid_q    <= 1'b0;
         result_q       <= '0;
         branch_taken_q <= 1'b0;
         zero_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         acc_q          <= acc_d;
         cnt_q          <= cnt_d;
         shift_kind_q   <= shift_kind_d;
         out_valid_q    <= out_valid_d;
         result_q       <= result_d;
         branch_taken_q <= branch_taken_d;
         zero_q         <= zero_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign result       = result_q;
   assign branch_taken = branch_taken_q;
   assign zero         = zero_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_iterative_alu.sv
// Purpose : self-checking bench for iterative_alu (table vectors, corner sequences, random vs model).
// Latency : n/a.
// Backpr. : drives out_ready high except in the explicit backpressure sequences.
module tb_iterative_alu;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   operation;
   logic [W-1:0] src_a;
   logic [W-1:0] src_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         branch_taken;
   logic         zero;
   logic         busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   iterative_alu #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .operation    (operation),
      .src_a        (src_a),
      .src_b        (src_b),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result),
      .branch_taken (branch_taken),
      .zero         (zero),
      .busy         (busy)
   );

   typedef struct {
      string      name;
      logic [3:0] op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        br;
      int          lat;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   // Reference: whole-operation semantics, shifts done in one go.
   function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] res, output logic br, output int lat);
      int sh;
      sh  = int'(b[4:0]);
      res = 32'h0;
      br  = 1'b0;
      lat = 1;
      case (op)
         4'd0:  res = a & b;
         4'd1:  res = a | b;
         4'd2:  res = a + b;
         4'd3:  res = a ^ b;
         4'd4:  begin res = a << sh; lat = 1 + sh; end
         4'd5:  begin res = a >> sh; lat = 1 + sh; end
         4'd6:  res = a - b;
         4'd7:  begin res = $unsigned($signed(a) >>> sh); lat = 1 + sh; end
         4'd8:  br = (a == b);
         4'd9:  br = (a != b);
         4'd10: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd11: res = (a < b) ? 32'd1 : 32'd0;
         4'd12: br = ($signed(a) < $signed(b));
         4'd13: br = ($signed(a) >= $signed(b));
         4'd14: br = (a < b);
         default: br = (a >= b);
      endcase
   endfunction

   // Issue one op from IDLE with out_ready=1, scramble inputs after accept, check the response.
   task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input logic exp_br,
                         input int exp_lat);
      int n;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      operation = op;
      src_a     = a;
      src_b     = b;
      settle();
      chk({name, " in_ready"}, 32'(in_ready), 32'd1);
      step();
      in_valid  = 1'b0;
      src_a     = $urandom;
      src_b     = $urandom;
      operation = 4'($urandom_range(0, 15));
      n = 1;
      while (!out_valid && n < 40) begin
         step();
         n++;
      end
      chk({name, " latency"}, 32'(n), 32'(exp_lat));
      chk({name, " result"}, result, exp_res);
      chk({name, " branch_taken"}, 32'(branch_taken), 32'(exp_br));
      chk({name, " zero"}, 32'(zero), (exp_res == 32'h0) ? 32'd1 : 32'd0);
      step();
      chk({name, " drained"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [3:0]  r_op;
      logic [31:0] r_a, r_b, r_res;
      logic        r_br;
      int          r_lat;
      int          seen;

      vecs[0]  = '{"add_wrap",  4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1};
      vecs[1]  = '{"sra4",      4'b0111, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 5};
      vecs[2]  = '{"blt",       4'b1100, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000, 1'b1, 1};
      vecs[3]  = '{"bltu",      4'b1110, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000, 1'b0, 1};
      vecs[4]  = '{"sll0",      4'b0100, 32'h0000_0001, 32'h0000_0020, 32'h0000_0001, 1'b0, 1};
      vecs[5]  = '{"srl31",     4'b0101, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 32};
      vecs[6]  = '{"and",       4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1};
      vecs[7]  = '{"or",        4'b0001, 32'h0000_F000, 32'h0000_0F0F, 32'h0000_FF0F, 1'b0, 1};
      vecs[8]  = '{"slt",       4'b1010, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001, 1'b0, 1};
      vecs[9]  = '{"sltu",      4'b1011, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000, 1'b0, 1};
      vecs[10] = '{"beq",       4'b1000, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b1, 1};
      vecs[11] = '{"bne",       4'b1001, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b0, 1};
      vecs[12] = '{"bge",       4'b1101, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1};
      vecs[13] = '{"bgeu",      4'b1111, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1};
      vecs[14] = '{"sub_wrap",  4'b0110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1};
      vecs[15] = '{"sll31",     4'b0100, 32'h0000_0003, 32'h0000_001F, 32'h8000_0000, 1'b0, 32};
      vecs[16] = '{"sra_pos",   4'b0111, 32'h7FFF_FFF0, 32'h0000_0004, 32'h07FF_FFFF, 1'b0, 5};

      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      operation = 4'h0;
      src_a     = '0;
      src_b     = '0;

      // Reset state
      step();
      step();
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst result", result, 32'h0);
      chk("rst branch_taken", 32'(branch_taken), 32'd0);
      chk("rst zero", 32'(zero), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      settle();
      chk("rst in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;

      // Table vectors
      for (int i = 0; i < 17; i++)
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].br, vecs[i].lat);

      // SRA busy window: 4 shift cycles stalled, result on the 5th
      out_ready = 1'b1;
      in_valid  = 1'b1;
      operation = 4'b0111;
      src_a     = 32'h8000_0000;
      src_b     = 32'h0000_0024;
      step();
      in_valid  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("sra busy", 32'(busy), 32'd1);
         chk("sra in_ready", 32'(in_ready), 32'd0);
         chk("sra no early valid", 32'(out_valid), 32'd0);
         step();
      end
      chk("sra out_valid", 32'(out_valid), 32'd1);
      chk("sra result", result, 32'hF800_0000);
      step();

      // Backpressure hold then back-to-back accept
      out_ready = 1'b0;
      in_valid  = 1'b1;
      operation = 4'b0110;
      src_a     = 32'd5;
      src_b     = 32'd7;
      step();
      in_valid  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("hold in_ready", 32'(in_ready), 32'd0);
         chk("hold out_valid", 32'(out_valid), 32'd1);
         chk("hold result", result, 32'hFFFF_FFFE);
         step();
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      operation = 4'b0011;
      src_a     = 32'h0000_F0F0;
      src_b     = 32'h0000_0FF0;
      settle();
      chk("b2b in_ready", 32'(in_ready), 32'd1);
      step();
      in_valid  = 1'b0;
      chk("b2b out_valid", 32'(out_valid), 32'd1);
      chk("b2b result", result, 32'h0000_FF00);
      chk("b2b zero", 32'(zero), 32'd0);
      step();
      chk("b2b drained", 32'(out_valid), 32'd0);

      // Flush on the third shift cycle, with a competing request
      in_valid  = 1'b1;
      operation = 4'b0100;
      src_a     = 32'h0000_0001;
      src_b     = 32'h0000_001F;
      step();
      in_valid  = 1'b0;
      step();
      step();
      flush     = 1'b1;
      in_valid  = 1'b1;
      operation = 4'b0010;
      src_a     = 32'd1;
      src_b     = 32'd1;
      settle();
      chk("flush in_ready", 32'(in_ready), 32'd0);
      step();
      flush     = 1'b0;
      in_valid  = 1'b0;
      chk("flush out_valid", 32'(out_valid), 32'd0);
      chk("flush busy", 32'(busy), 32'd0);
      settle();
      chk("flush idle in_ready", 32'(in_ready), 32'd1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) seen++;
         step();
      end
      chk("flush no late result", 32'(seen), 32'd0);

      // Flush while holding a result in DONE
      out_ready = 1'b0;
      in_valid  = 1'b1;
      operation = 4'b0010;
      src_a     = 32'd2;
      src_b     = 32'd3;
      step();
      in_valid  = 1'b0;
      chk("done pre-flush valid", 32'(out_valid), 32'd1);
      chk("done pre-flush result", result, 32'd5);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("done flush out_valid", 32'(out_valid), 32'd0);
      chk("done flush busy", 32'(busy), 32'd0);
      out_ready = 1'b1;

      // Randomised ops against the reference model
      for (int i = 0; i < 60; i++) begin
         r_op = 4'($urandom_range(0, 15));
         r_a  = $urandom;
         r_b  = $urandom;
         if ($urandom_range(0, 3) == 0) r_b = r_a;
         ref_alu(r_op, r_a, r_b, r_res, r_br, r_lat);
         run_op($sformatf("rand%0d op%0d", i, r_op), r_op, r_a, r_b, r_res, r_br, r_lat);
      end

      // Reset mid-shift after a held branch result
      out_ready = 1'b0;
      in_valid  = 1'b1;
      operation = 4'b1000;
      src_a     = 32'd7;
      src_b     = 32'd7;
      step();
      chk("pre-rst branch_taken", 32'(branch_taken), 32'd1);
      out_ready = 1'b1;
      operation = 4'b0101;
      src_a     = 32'h8000_0000;
      src_b     = 32'h0000_001F;
      step();
      in_valid  = 1'b0;
      step();
      step();
      chk("pre-rst busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("midrst out_valid", 32'(out_valid), 32'd0);
      chk("midrst result", result, 32'h0);
      chk("midrst branch_taken", 32'(branch_taken), 32'd0);
      chk("midrst zero", 32'(zero), 32'd0);
      chk("midrst busy", 32'(busy), 32'd0);
      settle();
      chk("midrst in_ready", 32'(in_ready), 32'd1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) seen++;
         step();
      end
      chk("midrst op discarded", 32'(seen), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
